decoder4_to_16: RTL and testbench
=================================

Name: decoder4_to_16

Overview:
- Registered 4-to-16 one-hot decoder in the datapath, used for register-select and write-enable generation.
- The 4-bit select {a,b,c,d} has a as MSB and d as LSB.
- Exactly one of y0..y15 is asserted: the output whose index equals the select value.
- Outputs are registered on clk. There is a synchronous, active-high reset.

Parameters:
- ACTIVE_LOW, default 0. 0 means the selected output is 1 and all others are 0. 1 means every output is inverted: selected output 0, others 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- y15  output  1  decode output, asserted when {a,b,c,d} = 4'b1111
- y14 .. y1  output  1 each  decode outputs; yN asserted when {a,b,c,d} = N
- y0  output  1  decode output, asserted when {a,b,c,d} = 4'b0000
- a  input  1  select bit 3 (MSB)
- b  input  1  select bit 2
- c  input  1  select bit 1
- d  input  1  select bit 0 (LSB)
- Positional port order: clk, rst, y15, y14, ..., y1, y0, a, b, c, d.

Behaviour:
- Select value: sel = {a,b,c,d}, unsigned 0..15.
- Next-state decode:
  - next[i] = (sel == i) for i = 0..15.
  - Exactly one bit of next is 1.
  - If ACTIVE_LOW = 1, next is bitwise inverted before the register.
- Latency: one clock. Inputs sampled at rising edge k appear on y at edge k (registered), stable until edge k+1.
- No combinational path from a/b/c/d to y.
- Reset:
  - When rst = 1 at a rising edge, all y outputs go to the deasserted level: 16'h0000 if ACTIVE_LOW = 0, 16'hFFFF if ACTIVE_LOW = 1.
  - The reset value is also the power-up target; the bench must reset before checking.
  - Reset has priority over decode and over the optional enable.
- Reset mid-operation: outputs go to the deasserted level on the edge rst is sampled high. On the first edge with rst = 0, outputs reflect the sel sampled on that edge.
- No state other than the 16 output flops. Back-to-back select changes every cycle are each reflected one cycle later, with no glitch across the clock edge.
- X/Z on a select bit: undefined output; not a supported use.
- Invariant after reset: outputs are always exactly one-hot (or one-cold when ACTIVE_LOW = 1).

Optional Feature:
- Macro: DECODER4_TO_16_ENABLE_EN.
- When defined:
  - Adds input port en (1 bit), placed after d in positional order.
  - When en = 1 at a rising edge, decode proceeds normally.
  - When en = 0 (and rst = 0), all outputs go to the deasserted level on that edge, so no output is selected.
  - rst still has priority over en.
- When not defined: no en port; the decoder behaves as if en were tied to 1.

Test Plan:
- Reset: rst = 1 for 2 cycles with sel = 4'b0101 -> all y = 0 (ACTIVE_LOW = 0); after release with sel = 4'b0000 -> next edge y0 = 1, all others 0.
- Exhaustive sweep: sel = 0..15, one value per clock (a,b,c,d from 0000 to 1111) -> one cycle later only y[sel] = 1, e.g. 4'b1010 -> y10 = 1, 4'b1111 -> y15 = 1; check one-hot every cycle.
- Latency check: change sel from 4'b0011 to 4'b1100 between edges -> y3 stays 1 until the next rising edge, then y12 = 1 and y3 = 0.
- Mid-operation reset: sweeping, assert rst while sel = 4'b0111 -> y all 0 on that edge; deassert with sel = 4'b1000 -> y8 = 1 on the next edge.
- ACTIVE_LOW = 1 instance: sel = 4'b0110 -> y6 = 0, all other outputs 1; under reset -> all outputs 1.
- With DECODER4_TO_16_ENABLE_EN: sel = 4'b1001, en = 1 -> y9 = 1; en = 0 -> all y = 0 next edge; rst = 1 with en = 1 -> all y = 0.

Source files
------------

// File: rtl/decoder4_to_16.sv
// decoder4_to_16: registered 4-to-16 one-hot decoder; DECODER4_TO_16_ENABLE_EN adds an en input.
module decoder4_to_16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic y15,
    output logic y14,
    output logic y13,
    output logic y12,
    output logic y11,
    output logic y10,
    output logic y9,
    output logic y8,
    output logic y7,
    output logic y6,
    output logic y5,
    output logic y4,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d
`ifdef DECODER4_TO_16_ENABLE_EN
    ,
    input  logic en
`endif
);
    logic [3:0]  sel;
    logic        go;
    logic [15:0] hot;
    logic [15:0] nxt;
    logic [15:0] y_q;

    assign sel = {a, b, c, d};
`ifdef DECODER4_TO_16_ENABLE_EN
    assign go = en;
`else
    assign go = 1'b1;
`endif

    // one-hot decode of the select, blanked when disabled, then polarity applied
    always_comb begin
        hot = go ? 16'd1 << sel : 16'd0;
        nxt = ACTIVE_LOW ? ~hot : hot;
    end

    // output register; reset drives every output to its deasserted level
    always_ff @(posedge clk) begin
        y_q <= rst ? {16{ACTIVE_LOW}} : nxt;
    end

    assign {y15, y14, y13, y12, y11, y10, y9, y8,
            y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
endmodule

// File: tb/tb_decoder4_to_16.sv
// tb_decoder4_to_16: scoreboard bench driving active-high and active-low decoders side by side.
module tb_decoder4_to_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic d = 1'b0;
`ifdef DECODER4_TO_16_ENABLE_EN
    logic en = 1'b1;
`endif
    logic [15:0] yh;
    logic [15:0] yl;

    typedef struct {
        string       tag;
        logic [15:0] hi;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder4_to_16 #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst),
        .y15(yh[15]), .y14(yh[14]), .y13(yh[13]), .y12(yh[12]),
        .y11(yh[11]), .y10(yh[10]), .y9(yh[9]), .y8(yh[8]),
        .y7(yh[7]), .y6(yh[6]), .y5(yh[5]), .y4(yh[4]),
        .y3(yh[3]), .y2(yh[2]), .y1(yh[1]), .y0(yh[0]),
        .a(a), .b(b), .c(c), .d(d)
`ifdef DECODER4_TO_16_ENABLE_EN
        , .en(en)
`endif
    );

    decoder4_to_16 #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst),
        .y15(yl[15]), .y14(yl[14]), .y13(yl[13]), .y12(yl[12]),
        .y11(yl[11]), .y10(yl[10]), .y9(yl[9]), .y8(yl[8]),
        .y7(yl[7]), .y6(yl[6]), .y5(yl[5]), .y4(yl[4]),
        .y3(yl[3]), .y2(yl[2]), .y1(yl[1]), .y0(yl[0]),
        .a(a), .b(b), .c(c), .d(d)
`ifdef DECODER4_TO_16_ENABLE_EN
        , .en(en)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] s, input logic r, input logic e);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = !r && e && (s == i[3:0]);
        return v;
    endfunction

    task automatic step(input string tag, input logic [3:0] s, input logic r, input logic e);
        exp_t x;
        {a, b, c, d} = s;
        rst = r;
`ifdef DECODER4_TO_16_ENABLE_EN
        en = e;
`endif
        x.tag = tag;
        x.hi = model(s, r, e);
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check({x.tag, "_hi"}, yh, x.hi);
        check({x.tag, "_lo"}, yl, ~x.hi);
        if (!r && e) check({x.tag, "_onehot"}, 16'($onehot(yh)), 16'd1);
    endtask

    initial begin
        step("rst0", 4'b0101, 1'b1, 1'b1);
        step("rst1", 4'b0101, 1'b1, 1'b1);
        step("rel", 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), i[3:0], 1'b0, 1'b1);
        step("lat3", 4'b0011, 1'b0, 1'b1);
        {a, b, c, d} = 4'b1100;
        #2;
        check("hold3", yh, 16'h0008);
        step("lat12", 4'b1100, 1'b0, 1'b1);
        step("mid5", 4'b0101, 1'b0, 1'b1);
        step("mid6", 4'b0110, 1'b0, 1'b1);
        step("mrst", 4'b0111, 1'b1, 1'b1);
        step("mrel", 4'b1000, 1'b0, 1'b1);
        step("al6", 4'b0110, 1'b0, 1'b1);
`ifdef DECODER4_TO_16_ENABLE_EN
        step("en1", 4'b1001, 1'b0, 1'b1);
        step("en0", 4'b1001, 1'b0, 1'b0);
        step("rsten", 4'b1001, 1'b1, 1'b1);
        step("rsten0", 4'b1001, 1'b1, 1'b0);
        step("en1b", 4'b1001, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 24; i++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 15));
            step($sformatf("rnd%0d", i), s, 1'b0, 1'b1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
